// File: rtl/dbg_pkg.sv
// Shared definitions for the debug capture block: trigger state encoding and
// the timestamp width used when DBG_TIMESTAMP_EN is defined.
package dbg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_POSTCAP = 2'd2,
    ST_FROZEN  = 2'd3
  } trig_state_t;

  localparam int TS_W = 16;

endpackage

// File: rtl/dbg_hist_ring.sv
// History ring: DEPTH entries of {channel, frame}, newest at read index 0.
// Optional per-entry timestamp storage when DBG_TIMESTAMP_EN is defined.
module dbg_hist_ring #(
  parameter int FRAME_W = 9,
  parameter int CH_W    = 2,
  parameter int DEPTH   = 8,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               wr_en,
  input  logic [CH_W-1:0]    wr_ch,
  input  logic [FRAME_W-1:0] wr_frame,
`ifdef DBG_TIMESTAMP_EN
  input  logic [dbg_pkg::TS_W-1:0] wr_ts,
  output logic [dbg_pkg::TS_W-1:0] rd_ts,
`endif
  input  logic [AW-1:0]      rd_idx,
  output logic [FRAME_W-1:0] rd_frame,
  output logic [CH_W-1:0]    rd_ch,
  output logic [AW:0]        count
);

  logic [FRAME_W-1:0] frame_mem [DEPTH];
  logic [CH_W-1:0]    ch_mem    [DEPTH];
`ifdef DBG_TIMESTAMP_EN
  logic [dbg_pkg::TS_W-1:0] ts_mem [DEPTH];
`endif
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_ptr;
  logic          rd_valid;

  // A clear in the same cycle as a write restarts the log with this entry
  assign wr_addr  = clr ? '0 : wr_ptr;
  assign rd_ptr   = wr_ptr - AW'(1) - rd_idx;
  assign rd_valid = {1'b0, rd_idx} < count;
  assign rd_frame = rd_valid ? frame_mem[rd_ptr] : '0;
  assign rd_ch    = rd_valid ? ch_mem[rd_ptr] : '0;
`ifdef DBG_TIMESTAMP_EN
  assign rd_ts    = rd_valid ? ts_mem[rd_ptr] : '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        frame_mem[i] <= '0;
        ch_mem[i]    <= '0;
`ifdef DBG_TIMESTAMP_EN
        ts_mem[i]    <= '0;
`endif
      end
    end else begin
      if (clr) begin
        wr_ptr <= wr_en ? AW'(1) : '0;
        count  <= wr_en ? (AW+1)'(1) : '0;
      end else if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (count != (AW+1)'(DEPTH)) count <= count + (AW+1)'(1);
      end
      if (wr_en) begin
        frame_mem[wr_addr] <= wr_frame;
        ch_mem[wr_addr]    <= wr_ch;
`ifdef DBG_TIMESTAMP_EN
        ts_mem[wr_addr]    <= wr_ts;
`endif
      end
    end
  end

endmodule

// File: rtl/debug_capture.sv
// Multi-channel debug capture: last frame/data per channel plus a frame history
// ring with match trigger and freeze. DBG_TIMESTAMP_EN adds per-entry cycle stamps.
//
// state      | meaning
// ST_IDLE    | ring logs freely, trigger disabled until arm
// ST_ARMED   | ring logs, waiting for a matching frame
// ST_POSTCAP | trigger seen, capturing the remaining post-trigger frames
// ST_FROZEN  | ring writes blocked until the next arm
module debug_capture
  import dbg_pkg::*;
#(
  parameter int FRAME_W = 9,
  parameter int DATA_W  = 4,
  parameter int CH_W    = 2,
  parameter int DEPTH   = 8,
  parameter int POST    = 2,
  localparam int AW     = $clog2(DEPTH),
  localparam int NUM_CH = 2**CH_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               debug,
  input  logic [CH_W-1:0]    channel,
  input  logic               frame_valid,
  input  logic [FRAME_W-1:0] frame,
  input  logic               data_out_valid,
  input  logic [DATA_W-1:0]  data_out,
  input  logic [CH_W-1:0]    rd_sel,
  input  logic [AW-1:0]      hist_idx,
  input  logic               trig_en,
  input  logic [FRAME_W-1:0] trig_frame,
  input  logic               arm,
`ifdef DBG_TIMESTAMP_EN
  output logic [TS_W-1:0]    hist_ts,
`endif
  output logic [FRAME_W-1:0] debug_frame,
  output logic [DATA_W-1:0]  debug_reg,
  output logic [CH_W-1:0]    debug_ch,
  output logic [FRAME_W-1:0] hist_frame,
  output logic [CH_W-1:0]    hist_ch,
  output logic [AW:0]        hist_count,
  output logic               frozen
);

  trig_state_t        state;
  logic [AW-1:0]      post_cnt;
  logic [FRAME_W-1:0] frame_r [NUM_CH];
  logic [DATA_W-1:0]  reg_r   [NUM_CH];
  logic               trig_hit;
  logic               ring_wr;
  logic               ring_rst;

  assign trig_hit    = frame_valid & trig_en & (frame == trig_frame);
  // arm clears the freeze in the same cycle, so its frame is always stored
  assign ring_wr     = frame_valid & (arm | (state != ST_FROZEN));
  assign ring_rst    = rst | ~debug;
  assign debug_frame = frame_r[rd_sel];
  assign debug_reg   = reg_r[rd_sel];

`ifdef DBG_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  always_ff @(posedge clk) begin
    if (rst || !debug || arm) ts <= '0;
    else                      ts <= ts + TS_W'(1);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst || !debug) begin
      state    <= ST_IDLE;
      post_cnt <= '0;
      frozen   <= 1'b0;
      debug_ch <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        frame_r[i] <= '0;
        reg_r[i]   <= '0;
      end
    end else begin
      debug_ch <= channel;
      if (frame_valid)    frame_r[channel] <= frame;
      if (data_out_valid) reg_r[channel]   <= data_out;
      if (arm) begin
        state    <= ST_ARMED;
        post_cnt <= '0;
        frozen   <= 1'b0;
      end else begin
        case (state)
          ST_ARMED: if (trig_hit) begin
            if (POST == 0) begin
              state  <= ST_FROZEN;
              frozen <= 1'b1;
            end else begin
              state    <= ST_POSTCAP;
              post_cnt <= AW'(POST);
            end
          end
          // Freeze once the last of the POST trailing frames has been stored
          ST_POSTCAP: if (frame_valid) begin
            if (post_cnt <= AW'(1)) begin
              state  <= ST_FROZEN;
              frozen <= 1'b1;
            end else begin
              post_cnt <= post_cnt - AW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  dbg_hist_ring #(
    .FRAME_W (FRAME_W),
    .CH_W    (CH_W),
    .DEPTH   (DEPTH)
  ) u_ring (
    .clk      (clk),
    .rst      (ring_rst),
    .clr      (arm),
    .wr_en    (ring_wr),
    .wr_ch    (channel),
    .wr_frame (frame),
`ifdef DBG_TIMESTAMP_EN
    .wr_ts    (arm ? '0 : ts),
    .rd_ts    (hist_ts),
`endif
    .rd_idx   (hist_idx),
    .rd_frame (hist_frame),
    .rd_ch    (hist_ch),
    .count    (hist_count)
  );

endmodule

// File: tb/tb_debug_capture.sv
// Bench for debug_capture: directed scenarios plus randomized traffic checked
// against a queue-based history model.
module tb_debug_capture;

  localparam int FRAME_W = 9;
  localparam int DATA_W  = 4;
  localparam int CH_W    = 2;
  localparam int DEPTH   = 8;
  localparam int POST    = 2;
  localparam int AW      = 3;
  localparam int NUM_CH  = 4;

  logic               clk = 1'b0;
  logic               rst, debug, frame_valid, data_out_valid, trig_en, arm;
  logic [CH_W-1:0]    channel, rd_sel, debug_ch, hist_ch;
  logic [FRAME_W-1:0] frame, trig_frame, debug_frame, hist_frame;
  logic [DATA_W-1:0]  data_out, debug_reg;
  logic [AW-1:0]      hist_idx;
  logic [AW:0]        hist_count;
  logic               frozen;
`ifdef DBG_TIMESTAMP_EN
  logic [15:0]        hist_ts;
`endif

  debug_capture #(
    .FRAME_W(FRAME_W), .DATA_W(DATA_W), .CH_W(CH_W), .DEPTH(DEPTH), .POST(POST)
  ) dut (
    .clk(clk), .rst(rst), .debug(debug), .channel(channel),
    .frame_valid(frame_valid), .frame(frame),
    .data_out_valid(data_out_valid), .data_out(data_out),
    .rd_sel(rd_sel), .hist_idx(hist_idx), .trig_en(trig_en),
    .trig_frame(trig_frame), .arm(arm),
`ifdef DBG_TIMESTAMP_EN
    .hist_ts(hist_ts),
`endif
    .debug_frame(debug_frame), .debug_reg(debug_reg), .debug_ch(debug_ch),
    .hist_frame(hist_frame), .hist_ch(hist_ch), .hist_count(hist_count),
    .frozen(frozen)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: history is a newest-first queue capped at DEPTH
  typedef struct {
    logic [CH_W-1:0]    ch;
    logic [FRAME_W-1:0] fr;
  } ent_t;

  ent_t               m_hist[$];
  logic [FRAME_W-1:0] m_frame [NUM_CH];
  logic [DATA_W-1:0]  m_reg   [NUM_CH];
  logic [CH_W-1:0]    m_ch;
  int                 m_mode;   // 0 idle, 1 waiting for match, 2 post capture, 3 done
  int                 m_left;
  bit                 m_frozen;

  task automatic model_clear();
    for (int i = 0; i < NUM_CH; i++) begin
      m_frame[i] = '0;
      m_reg[i]   = '0;
    end
    m_hist.delete();
    m_ch = '0; m_mode = 0; m_left = 0; m_frozen = 0;
  endtask

  task automatic model_push(input logic [CH_W-1:0] c, input logic [FRAME_W-1:0] f);
    ent_t e;
    e.ch = c; e.fr = f;
    m_hist.push_front(e);
    if (m_hist.size() > DEPTH) void'(m_hist.pop_back());
  endtask

  task automatic model_update();
    if (rst || !debug) begin
      model_clear();
    end else begin
      m_ch = channel;
      if (frame_valid)    m_frame[channel] = frame;
      if (data_out_valid) m_reg[channel]   = data_out;
      if (arm) begin
        m_hist.delete();
        if (frame_valid) model_push(channel, frame);
        m_mode = 1; m_frozen = 0;
      end else begin
        if (frame_valid && !m_frozen) model_push(channel, frame);
        if (m_mode == 1 && frame_valid && trig_en && frame == trig_frame) begin
          m_left = POST;
          if (m_left == 0) begin m_frozen = 1; m_mode = 3; end
          else m_mode = 2;
        end else if (m_mode == 2 && frame_valid) begin
          m_left--;
          if (m_left == 0) begin m_frozen = 1; m_mode = 3; end
        end
      end
    end
  endtask

  task automatic check_model();
    logic [FRAME_W-1:0] ef;
    logic [CH_W-1:0]    ec;
    ef = '0; ec = '0;
    if (int'(hist_idx) < m_hist.size()) begin
      ef = m_hist[hist_idx].fr;
      ec = m_hist[hist_idx].ch;
    end
    check("debug_frame", debug_frame, m_frame[rd_sel]);
    check("debug_reg",   debug_reg,   m_reg[rd_sel]);
    check("debug_ch",    debug_ch,    m_ch);
    check("hist_frame",  hist_frame,  ef);
    check("hist_ch",     hist_ch,     ec);
    check("hist_count",  hist_count,  m_hist.size());
    check("frozen",      frozen,      m_frozen);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
    rst = 0; arm = 0; frame_valid = 0; data_out_valid = 0;
  endtask

  task automatic send_frame(input int c, input int f);
    channel = CH_W'(c); frame = FRAME_W'(f); frame_valid = 1;
    step();
  endtask

  task automatic peek(input int idx);
    hist_idx = AW'(idx);
    #1;
  endtask

  initial begin
    rst = 1; debug = 1; channel = 0; frame_valid = 0; frame = 0;
    data_out_valid = 0; data_out = 0; rd_sel = 0; hist_idx = 0;
    trig_en = 0; trig_frame = 9'h0AA; arm = 0;
    model_clear();
    step();

    // Reset and blanking
    send_frame(1, 9'h055);
    channel = 1; data_out = 4'h7; data_out_valid = 1; step();
    rd_sel = 1; rst = 1; step();
    check("rst_debug_frame", debug_frame, 0);
    check("rst_debug_reg", debug_reg, 0);
    check("rst_hist_count", hist_count, 0);
    send_frame(1, 9'h033);
    debug = 0; step();
    check("blank_debug_frame", debug_frame, 0);
    check("blank_hist_count", hist_count, 0);
    debug = 1; step();

    // Per-channel stores
    send_frame(1, 9'h1A5);
    channel = 2; data_out = 4'h9; data_out_valid = 1; step();
    rd_sel = 1; #1; check("ch1_frame", debug_frame, 9'h1A5);
    rd_sel = 2; #1; check("ch2_reg", debug_reg, 4'h9);

    // Wrap-around in IDLE
    rst = 1; step();
    for (int i = 1; i <= 3; i++) send_frame(0, i);
    peek(5); check("idx_beyond_count", hist_frame, 0);
    for (int i = 4; i <= 10; i++) send_frame(0, i);
    check("wrap_count", hist_count, DEPTH);
    peek(0); check("wrap_idx0", hist_frame, 10);
    peek(7); check("wrap_idx7", hist_frame, 3);

    // Trigger with POST=2
    trig_en = 1; arm = 1; step();
    send_frame(0, 5); send_frame(0, 6); send_frame(3, 9'h0AA);
    send_frame(0, 7);
    check("not_yet_frozen", frozen, 0);
    send_frame(0, 8);
    check("frozen_after_post", frozen, 1);
    send_frame(0, 9);
    peek(0); check("trig_idx0", hist_frame, 8);
    peek(2); check("trig_idx2", hist_frame, 9'h0AA);
    check("trig_idx2_ch", hist_ch, 3);
    check("trig_count", hist_count, 5);

    // Re-arm with a matching frame in the same cycle
    arm = 1; channel = 0; frame = 9'h0AA; frame_valid = 1; step();
    check("rearm_frozen", frozen, 0);
    check("rearm_count", hist_count, 1);
    peek(0); check("rearm_idx0", hist_frame, 9'h0AA);
    send_frame(0, 9'h0AA); send_frame(0, 1); send_frame(0, 2);
    check("rearm_armed", frozen, 1);

`ifdef DBG_TIMESTAMP_EN
    arm = 1; step();
    step(); step();
    send_frame(0, 1);
    step(); step(); step();
    send_frame(0, 2);
    peek(0);
    begin
      logic [15:0] t0;
      t0 = hist_ts;
      peek(1);
      check("ts_delta", 32'(t0 - hist_ts), 4);
    end
`endif

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst            = ($urandom_range(0, 199) == 0);
      debug          = ($urandom_range(0, 99) != 0);
      arm            = ($urandom_range(0, 39) == 0);
      trig_en        = ($urandom_range(0, 9) != 0);
      channel        = CH_W'($urandom);
      frame_valid    = $urandom_range(0, 1);
      frame          = ($urandom_range(0, 3) == 0) ? trig_frame : FRAME_W'($urandom);
      data_out_valid = ($urandom_range(0, 2) == 0);
      data_out       = DATA_W'($urandom);
      rd_sel         = CH_W'($urandom);
      hist_idx       = AW'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
